// File: rtl/adder_selftest.sv
// adder_selftest: built-in self-test engine for a WIDTH-bit ripple adder.
// Sweeps every {opA,opB} pair (opA-major). Each vector gets SETTLE settle
// cycles and then one check cycle. Sum, carry-out and signed overflow are
// compared against a golden result. The engine counts mismatches and
// captures the first failing vector.
//
// Ports:
//   clk, reset       rising-edge clock, asynchronous active-high reset
//   start            one-cycle pulse; starts a sweep when idle or done
//   opA, opB         registered operands driven to the adder
//   sum, carryout,
//   overflow         adder responses under test
//   busy, done, pass sweep status (pass = done with zero mismatches)
//   err_count        mismatching vectors in the current or last sweep
//   fail_valid,
//   fail_a, fail_b   first failing vector
module adder_selftest #(
  parameter int WIDTH  = 4,
  parameter int SETTLE = 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [WIDTH-1:0]   opA,
  output logic [WIDTH-1:0]   opB,
  input  logic [WIDTH-1:0]   sum,
  input  logic               carryout,
  input  logic               overflow,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic               fail_valid,
  output logic [WIDTH-1:0]   fail_a,
  output logic [WIDTH-1:0]   fail_b
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] LOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_DONE
  } state_t;

  state_t          state;
  logic [CW-1:0]   settle_cnt;

  logic [WIDTH:0]  exp_full;
  logic            exp_v;
  logic            mismatch;
  logic            last_vec;

  // Golden result for the operands currently driven to the adder.
  always_comb begin
    exp_full = {1'b0, opA} + {1'b0, opB};
    exp_v    = (opA[WIDTH-1] == opB[WIDTH-1]) &&
               (exp_full[WIDTH-1] != opA[WIDTH-1]);
    mismatch = (sum != exp_full[WIDTH-1:0]) ||
               (carryout != exp_full[WIDTH]) ||
               (overflow != exp_v);
    last_vec = &{opA, opB};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      settle_cnt <= '0;
      opA        <= '0;
      opB        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_valid <= 1'b0;
      fail_a     <= '0;
      fail_b     <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            opA        <= '0;
            opB        <= '0;
            err_count  <= '0;
            fail_valid <= 1'b0;
            fail_a     <= '0;
            fail_b     <= '0;
            done       <= 1'b0;
            pass       <= 1'b0;
            busy       <= 1'b1;
            settle_cnt <= LOAD;
            state      <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt - CW'(1);
          end
        end
        S_CHECK: begin
          if (mismatch) begin
            err_count <= err_count + (2*WIDTH+1)'(1);
            if (!fail_valid) begin
              fail_valid <= 1'b1;
              fail_a     <= opA;
              fail_b     <= opB;
            end
          end
          if (last_vec) begin
            // pass must include a mismatch on the final vector, which is
            // not yet reflected in the registered err_count.
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_count == '0) && !mismatch;
            state <= S_DONE;
          end else begin
            {opA, opB} <= {opA, opB} + (2*WIDTH)'(1);
            settle_cnt <= LOAD;
            state      <= S_SETTLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_selftest.sv
// Testbench for adder_selftest. A behavioural 4-bit adder with selectable
// faults sits beside the DUT. Expected sweep results come from a reference
// model that enumerates all operand pairs with plain integer arithmetic.
module tb_adder_selftest;

  logic       clk;
  logic       reset;
  logic       start;
  logic [3:0] opA, opB, sum;
  logic       carryout, overflow;
  logic       busy, done, pass, fail_valid;
  logic [8:0] err_count;
  logic [3:0] fail_a, fail_b;

  int n_checks = 0;
  int n_pass   = 0;

  // 0 = correct, 1 = overflow stuck 0, 2 = carryout stuck 0,
  // 3 = sum bit 0 flipped on a random set of vectors
  int fault = 0;
  bit bad [256];

  adder_selftest #(.WIDTH(4), .SETTLE(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .opA        (opA),
    .opB        (opB),
    .sum        (sum),
    .carryout   (carryout),
    .overflow   (overflow),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .err_count  (err_count),
    .fail_valid (fail_valid),
    .fail_a     (fail_a),
    .fail_b     (fail_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural adder under test, with fault injection.
  logic [4:0] add_full;
  logic       add_v;
  always_comb begin
    add_full = {1'b0, opA} + {1'b0, opB};
    add_v    = (opA[3] == opB[3]) && (add_full[3] != opA[3]);
    sum      = add_full[3:0] ^ {3'b000, (fault == 3) && bad[{opA, opB}]};
    carryout = (fault == 2) ? 1'b0 : add_full[4];
    overflow = (fault == 1) ? 1'b0 : add_v;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Reference: enumerate all pairs opA-major and count fault-visible errors.
  task automatic model(output int errs, output int fa, output int fb, output bit fv);
    errs = 0; fa = 0; fb = 0; fv = 0;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        int sa, sb, s, ss;
        bit err;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        s  = a + b;
        ss = sa + sb;
        err = (fault == 1 && (ss > 7 || ss < -8)) ||
              (fault == 2 && s > 15) ||
              (fault == 3 && bad[a*16 + b]);
        if (err) begin
          if (!fv) begin fv = 1; fa = a; fb = b; end
          errs++;
        end
      end
    end
  endtask

  task automatic check_results(input string tag);
    int errs, fa, fb;
    bit fv;
    model(errs, fa, fb, fv);
    check({tag, "_err_count"}, 32'(err_count), 32'(errs));
    check({tag, "_fail_valid"}, 32'(fail_valid), 32'(fv));
    check({tag, "_pass"}, 32'(pass), 32'(errs == 0));
    check({tag, "_done"}, 32'(done), 1);
    if (fv) begin
      check({tag, "_fail_a"}, 32'(fail_a), 32'(fa));
      check({tag, "_fail_b"}, 32'(fail_b), 32'(fb));
    end
  endtask

  // Pulse start, then run until done. inject_at: cycle index at which a
  // spurious start is pulsed mid-sweep. reset_at: cycle index at which
  // reset is asserted to abort the sweep (-1 disables).
  task automatic run_sweep(input string tag, input int inject_at, input int reset_at);
    int n;
    logic [7:0] prev;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({tag, "_busy_rise"}, 32'(busy), 1);
    check({tag, "_start_clears_err"}, 32'(err_count), 0);
    check({tag, "_start_clears_done"}, 32'(done), 0);
    check({tag, "_start_clears_fv"}, 32'(fail_valid), 0);
    n = 0;
    prev = {opA, opB};
    while (!done && n < 2000) begin
      start = (n == inject_at);
      @(posedge clk);
      #1;
      n++;
      if (fault == 0 && {opA, opB} != prev &&
          (prev == 8'h44 || prev == 8'h88 || prev == 8'h6F))
        check($sformatf("%s_spot_%02h", tag, prev), 32'(err_count), 0);
      prev = {opA, opB};
      if (n == reset_at) begin
        reset = 1'b1;
        #1;
        check({tag, "_rst_busy"}, 32'(busy), 0);
        check({tag, "_rst_err"}, 32'(err_count), 0);
        check({tag, "_rst_ops"}, 32'({opA, opB}), 0);
        check({tag, "_rst_fv"}, 32'({fail_valid, fail_a, fail_b}), 0);
        check({tag, "_rst_done"}, 32'({done, pass}), 0);
        @(negedge clk);
        reset = 1'b0;
        return;
      end
    end
    start = 1'b0;
    check({tag, "_sweep_len"}, 32'(n), 768);
    check({tag, "_busy_fall"}, 32'(busy), 0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'({done, pass}), 0);
    check("rst_err", 32'(err_count), 0);
    check("rst_fail", 32'({fail_valid, fail_a, fail_b}), 0);
    check("rst_ops", 32'({opA, opB}), 0);
    @(negedge clk);
    reset = 1'b0;

    fault = 0;
    run_sweep("good", 100, -1);
    check_results("good");

    fault = 1;
    run_sweep("ovf", -1, -1);
    check_results("ovf");

    fault = 2;
    run_sweep("cout", -1, -1);
    check_results("cout");

    fault = 1;
    run_sweep("abort", -1, 300);
    check("abort_idle_stays", 32'(busy), 0);
    run_sweep("ovf2", -1, -1);
    check_results("ovf2");

    fault = 3;
    for (int i = 0; i < 256; i++) bad[i] = ($urandom_range(7) == 0);
    bad[255] = 1'b1;
    repeat ($urandom_range(5)) @(posedge clk);
    run_sweep("rand", -1, -1);
    check_results("rand");

    for (int i = 0; i < 256; i++) bad[i] = ($urandom_range(15) == 0);
    bad[255] = 1'b0;
    run_sweep("rand2", $urandom_range(700, 10), -1);
    check_results("rand2");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
